// File: rtl/rv32i_core_if.sv
// Internal memory bus of the rv32i core: one instruction read port, one data
// read port and one byte-enabled data write port, all word-addressed.
interface rv32i_core_if #(
    parameter int AW = 16
);
    logic [AW-1:0] iaddr;
    logic [31:0]   idata;
    logic [AW-1:0] daddr;
    logic [31:0]   rdata;
    logic [31:0]   wdata;
    logic [3:0]    be;

    modport master (output iaddr, daddr, wdata, be, input idata, rdata);
    modport slave  (input iaddr, daddr, wdata, be, output idata, rdata);
endinterface

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with unified word memory, 32x32 register file and a
// flat 4096-entry machine-mode CSR array; all state is observed hierarchically.
module rv32i_mem #(
    parameter int MEM_WORDS = 65536
) (
    input logic          clk,
    rv32i_core_if.slave  bus
);
    logic [31:0] m [0:MEM_WORDS-1];

    assign bus.idata = m[bus.iaddr];
    assign bus.rdata = m[bus.daddr];

    // NOTE: the memory array has no reset; its contents are preloaded and a
    // reset loop over it would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) m[bus.daddr][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MHARTID = 12'hF14;

    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    rv32i_core_if #(.AW(AW)) mbus ();
    rv32i_mem #(.MEM_WORDS(MEM_WORDS)) memory (.clk(clk), .bus(mbus.slave));

    logic [31:0] instr;
    opcode_e     opcode;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr_a;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rv1, rv2, pc_plus4, ld_addr, st_addr, csr_old, csr_src;

    assign mbus.iaddr = pc[AW+1:2];
    assign instr      = mbus.idata;
    assign opcode     = opcode_e'(instr[6:0]);
    assign rd_a       = instr[11:7];
    assign funct3     = instr[14:12];
    assign rs1_a      = instr[19:15];
    assign rs2_a      = instr[24:20];
    assign funct7     = instr[31:25];
    assign csr_a      = instr[31:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rv1      = (rs1_a == 5'd0) ? 32'd0 : rs[rs1_a];
    assign rv2      = (rs2_a == 5'd0) ? 32'd0 : rs[rs2_a];
    assign pc_plus4 = pc + 32'd4;
    assign ld_addr  = rv1 + imm_i;
    assign st_addr  = rv1 + imm_s;
    assign csr_old  = (csr_a == CSR_MHARTID) ? 32'd0 : csr[csr_a];
    assign csr_src  = funct3[2] ? {27'd0, rs1_a} : rv1;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    logic [31:0] next_pc, rd_val, csr_wval, st_data, mem_addr, ld_lane;
    logic        rd_we, csr_we, is_ecall;
    logic [3:0]  st_be;

    assign ld_lane = mbus.rdata >> {mem_addr[1:0], 3'b000};

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        next_pc  = pc_plus4;
        rd_we    = 1'b0;
        rd_val   = 32'd0;
        csr_we   = 1'b0;
        csr_wval = 32'd0;
        is_ecall = 1'b0;
        st_be    = 4'b0000;
        st_data  = 32'd0;
        mem_addr = ld_addr;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = pc + imm_j; end
            OP_JALR:   begin rd_we = 1'b1; rd_val = pc_plus4; next_pc = ld_addr & ~32'd1; end
            OP_BRANCH: if (branch_taken(funct3, rv1, rv2)) next_pc = pc + imm_b;
            OP_LOAD: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
                    3'b001:  rd_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
                    3'b010:  rd_val = mbus.rdata;
                    3'b100:  rd_val = {24'd0, ld_lane[7:0]};
                    3'b101:  rd_val = {16'd0, ld_lane[15:0]};
                    default: rd_we  = 1'b0;
                endcase
            end
            OP_STORE: begin
                mem_addr = st_addr;
                case (funct3)
                    3'b000: begin st_data = {4{rv2[7:0]}};  st_be = 4'b0001 << st_addr[1:0]; end
                    3'b001: begin st_data = {2{rv2[15:0]}}; st_be = st_addr[1] ? 4'b1100 : 4'b0011; end
                    3'b010: begin st_data = rv2;            st_be = 4'b1111; end
                    default: ;
                endcase
            end
            OP_IMM: begin
                rd_we  = 1'b1;
                rd_val = alu(funct3, (funct3 == 3'b101) && funct7[5], rv1, imm_i);
            end
            OP_REG: begin
                rd_we  = 1'b1;
                rd_val = alu(funct3, funct7[5], rv1, rv2);
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    if (csr_a == 12'h000) begin
                        is_ecall = 1'b1;
                        next_pc  = csr[CSR_MTVEC] & ~32'd3;
                    end else if (csr_a == 12'h302) begin
                        next_pc = csr[CSR_MEPC];
                    end
                end else if (funct3[1:0] != 2'b00) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    // Set/clear with a zero source is a pure read and leaves the CSR alone.
                    case (funct3[1:0])
                        2'b01:   begin csr_we = 1'b1;            csr_wval = csr_src; end
                        2'b10:   begin csr_we = rs1_a != 5'd0;   csr_wval = csr_old | csr_src; end
                        default: begin csr_we = rs1_a != 5'd0;   csr_wval = csr_old & ~csr_src; end
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign mbus.daddr = mem_addr[AW+1:2];
    assign mbus.wdata = st_data;
    assign mbus.be    = rst ? 4'b0000 : st_be;

    // NOTE: architectural state uses non-blocking assignments so every write in
    // a cycle sees the pre-edge values of pc, rs and csr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++)   rs[i]  <= 32'd0;
            for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd_a != 5'd0) rs[rd_a] <= rd_val;
            if (csr_we) csr[csr_a] <= csr_wval;
            if (is_ecall) begin
                csr[CSR_MEPC]   <= pc;
                csr[CSR_MCAUSE] <= 32'd11;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: programs are poked into memory, run for a fixed number
// of cycles, and architectural state is compared with expected values.
module tb_rv32i_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_core dut (.clk(clk), .rst(rst));

    int n_pass  = 0;
    int n_total = 0;
    int pc_w    = 0;

    localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, SYS = 7'b1110011;
    localparam logic [6:0] LUI = 7'b0110111, JALR = 7'b1100111;

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI
    } op_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    // Reference semantics of the randomized ALU ops, straight from the ISA definition.
    function automatic logic [31:0] model(input op_e k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            K_ADD, K_ADDI:   return a + b;
            K_SUB:           return a - b;
            K_SLL, K_SLLI:   return a << b[4:0];
            K_SLT, K_SLTI:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU, K_SLTIU: return (a < b) ? 32'd1 : 32'd0;
            K_XOR, K_XORI:   return a ^ b;
            K_OR, K_ORI:     return a | b;
            K_AND, K_ANDI:   return a & b;
            K_SRL, K_SRLI:   return a >> b[4:0];
            default:         return 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    function automatic logic [2:0] f3_of(input op_e k);
        case (k)
            K_ADD, K_SUB, K_ADDI:   return 3'b000;
            K_SLL, K_SLLI:          return 3'b001;
            K_SLT, K_SLTI:          return 3'b010;
            K_SLTU, K_SLTIU:        return 3'b011;
            K_XOR, K_XORI:          return 3'b100;
            K_SRL, K_SRA, K_SRLI, K_SRAI: return 3'b101;
            K_OR, K_ORI:            return 3'b110;
            default:                return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic begin_prog();
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) dut.memory.m[i] = 32'h0;
        pc_w = 0;
    endtask
    task automatic emit(input logic [31:0] ins);
        dut.memory.m[pc_w >> 2] = ins;
        pc_w += 4;
    endtask
    task automatic li(input logic [4:0] rd, input logic [31:0] v);
        logic [31:0] hi;
        hi = (v + 32'h800) >> 12;
        emit({hi[19:0], rd, LUI});
        emit(enc_i(v[11:0], rd, 3'b000, rd, OPI));
    endtask
    task automatic run(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] acc, a, b;
        logic [11:0] imm;
        op_e k;

        // Asynchronous reset in the middle of a running program.
        begin_prog();
        li(5'd1, 32'hCAFE_0001);
        emit(enc_i(12'h100, 5'd0, 3'b000, 5'd2, OPI));
        emit(enc_s(12'd0, 5'd1, 5'd2, 3'b010));
        emit(enc_j(21'd0, 5'd0));
        run(3);
        check("pre_reset_x1", dut.rs[1], 32'hCAFE_0001);
        check("pre_reset_pc", dut.pc, 32'h0000_000C);
        #2 rst = 1'b1;
        #1;
        check("reset_pc", dut.pc, 32'h0);
        acc = 32'h0;
        for (int i = 1; i < 32; i++) acc |= dut.rs[i];
        check("reset_regs", acc, 32'h0);
        @(negedge clk);
        check("reset_no_store", dut.memory.m[64], 32'h0);

        // ALU basics and x0 write discard.
        begin_prog();
        emit(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI));
        emit(enc_r(7'd0, 5'd1, 5'd1, 3'b111, 5'd2));
        emit(enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd3));
        emit(enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI));
        emit(enc_j(21'd0, 5'd0));
        run(8);
        check("alu_x1", dut.rs[1], 32'hFFFF_FFFF);
        check("alu_x2", dut.rs[2], 32'hFFFF_FFFF);
        check("alu_x3", dut.rs[3], 32'h0000_0001);
        check("alu_x0", dut.rs[0], 32'h0);

        // Loads and stores with byte lanes.
        begin_prog();
        li(5'd1, 32'h1234_5678);
        emit(enc_i(12'h100, 5'd0, 3'b000, 5'd2, OPI));
        emit(enc_s(12'd0, 5'd1, 5'd2, 3'b010));
        emit(enc_i(12'd3, 5'd2, 3'b000, 5'd3, LD));
        emit(enc_i(12'd3, 5'd2, 3'b100, 5'd4, LD));
        emit(enc_i(12'h080, 5'd0, 3'b000, 5'd5, OPI));
        emit(enc_s(12'd1, 5'd5, 5'd2, 3'b000));
        emit(enc_i(12'd0, 5'd2, 3'b010, 5'd6, LD));
        emit(enc_i(12'd0, 5'd2, 3'b001, 5'd7, LD));
        emit(enc_i(12'd2, 5'd2, 3'b101, 5'd8, LD));
        emit(enc_i(12'd1, 5'd2, 3'b000, 5'd10, LD));
        emit(enc_s(12'd2, 5'd5, 5'd2, 3'b001));
        emit(enc_i(12'd0, 5'd2, 3'b010, 5'd9, LD));
        emit(enc_j(21'd0, 5'd0));
        run(20);
        check("mem_lb", dut.rs[3], 32'h0000_0012);
        check("mem_lbu", dut.rs[4], 32'h0000_0012);
        check("mem_sb_lw", dut.rs[6], 32'h1234_8078);
        check("mem_lh", dut.rs[7], 32'hFFFF_8078);
        check("mem_lhu", dut.rs[8], 32'h0000_1234);
        check("mem_lb_neg", dut.rs[10], 32'hFFFF_FF80);
        check("mem_sh_lw", dut.rs[9], 32'h0080_8078);
        check("mem_word", dut.memory.m[64], 32'h0080_8078);

        // Branches, JAL and JALR with an odd target.
        begin_prog();
        emit(enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI));
        emit(enc_b(13'd8, 5'd1, 5'd1, 3'b000));
        emit(enc_i(12'd99, 5'd0, 3'b000, 5'd2, OPI));
        emit(enc_b(13'd8, 5'd0, 5'd1, 3'b000));
        emit(enc_i(12'd7, 5'd0, 3'b000, 5'd3, OPI));
        emit(enc_j(21'd8, 5'd4));
        emit(enc_i(12'd99, 5'd0, 3'b000, 5'd5, OPI));
        emit(enc_i(12'h02D, 5'd0, 3'b000, 5'd6, OPI));
        emit(enc_i(12'd0, 5'd6, 3'b000, 5'd7, JALR));
        emit(enc_i(12'd99, 5'd0, 3'b000, 5'd8, OPI));
        emit(enc_i(12'd98, 5'd0, 3'b000, 5'd8, OPI));
        emit(enc_i(12'd3, 5'd0, 3'b000, 5'd9, OPI));
        emit(enc_j(21'd0, 5'd0));
        run(20);
        check("beq_taken_skip", dut.rs[2], 32'd0);
        check("beq_not_taken", dut.rs[3], 32'd7);
        check("jal_link", dut.rs[4], 32'h18);
        check("jal_skip", dut.rs[5], 32'd0);
        check("jalr_link", dut.rs[7], 32'h24);
        check("jalr_skip", dut.rs[8], 32'd0);
        check("jalr_target", dut.rs[9], 32'd3);
        check("ctrl_pc", dut.pc, 32'h30);

        // ECALL / MRET and CSR read-modify-write.
        begin_prog();
        emit(enc_i(12'h200, 5'd0, 3'b000, 5'd1, OPI));
        emit(enc_i(12'h305, 5'd1, 3'b001, 5'd0, SYS));
        emit(enc_i(12'hF14, 5'd1, 3'b001, 5'd0, SYS));
        emit(enc_j(21'h34, 5'd0));
        pc_w = 32'h40;
        emit(32'h0000_0073);
        emit(enc_j(21'd0, 5'd0));
        pc_w = 32'h200;
        emit(enc_i(12'h342, 5'd0, 3'b010, 5'd10, SYS));
        emit(enc_i(12'h341, 5'd0, 3'b010, 5'd11, SYS));
        emit(enc_i(12'hF14, 5'd0, 3'b010, 5'd12, SYS));
        emit(enc_i(12'h340, 5'd5, 3'b101, 5'd13, SYS));
        emit(enc_i(12'h340, 5'd1, 3'b111, 5'd14, SYS));
        emit(32'h3020_0073);
        run(5);
        check("trap_mtvec", dut.csr[12'h305], 32'h200);
        check("trap_pc", dut.pc, 32'h200);
        check("trap_mepc", dut.csr[12'h341], 32'h40);
        check("trap_mcause", dut.csr[12'h342], 32'd11);
        repeat (6) @(negedge clk);
        check("mret_pc", dut.pc, 32'h40);
        check("csrr_mcause", dut.rs[10], 32'd11);
        check("csrr_mepc", dut.rs[11], 32'h40);
        check("mhartid_zero", dut.rs[12], 32'd0);
        check("csrrwi_old", dut.rs[13], 32'd0);
        check("csrrci_old", dut.rs[14], 32'd5);
        check("csrrci_new", dut.csr[12'h340], 32'd4);

        // Randomized single ALU ops against the reference model.
        for (int it = 0; it < 40; it++) begin
            k = op_e'($urandom_range(0, 18));
            a = pick();
            b = pick();
            begin_prog();
            li(5'd1, a);
            li(5'd2, b);
            if (k <= K_AND) begin
                emit(enc_r((k == K_SUB || k == K_SRA) ? 7'b0100000 : 7'd0,
                           5'd2, 5'd1, f3_of(k), 5'd3));
            end else begin
                imm = 12'($urandom);
                if (k == K_SLLI || k == K_SRLI) imm = {7'd0, imm[4:0]};
                if (k == K_SRAI) imm = {7'b0100000, imm[4:0]};
                b = (k == K_SRAI) ? {27'd0, imm[4:0]} : {{20{imm[11]}}, imm};
                emit(enc_i(imm, 5'd1, f3_of(k), 5'd3, OPI));
            end
            emit(enc_j(21'd0, 5'd0));
            run(8);
            check($sformatf("rand%0d_%s a=%08h b=%08h", it, k.name(), a, b),
                  dut.rs[3], model(k, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
